// File: rtl/pipe_redirect_ctrl_if.sv
// rtl/pipe_redirect_ctrl_if.sv - hazard/redirect bundle between pipeline and pipe_redirect_ctrl
// Stats signals exist only when PIPE_REDIRECT_STATS_EN is defined.
interface pipe_redirect_ctrl_if #(
  parameter int ADDR_W = 32
`ifdef PIPE_REDIRECT_STATS_EN
  , parameter int CNT_W = 32
`endif
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_mem;
  logic              ex_jmp_en;
  logic [ADDR_W-1:0] ex_jmp_target;
  logic              if_pred_en;
  logic [ADDR_W-1:0] if_pred_target;
  logic [5:0]        stall;
  logic              pc_jmp_enable;
  logic [ADDR_W-1:0] pc_jmp_target;
  logic              pc_pred_enable;
  logic [ADDR_W-1:0] pc_prediction;
  logic              flush_if;
  logic              flush_id;
  logic              redirect_busy;
`ifdef PIPE_REDIRECT_STATS_EN
  logic [CNT_W-1:0]  stat_stall_cycles;
  logic [CNT_W-1:0]  stat_redirects;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem,
    output ex_jmp_en, ex_jmp_target, if_pred_en, if_pred_target,
    input  stall, pc_jmp_enable, pc_jmp_target, pc_pred_enable, pc_prediction,
    input  flush_if, flush_id, redirect_busy
`ifdef PIPE_REDIRECT_STATS_EN
    , input stat_stall_cycles, stat_redirects
`endif
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem,
    input  ex_jmp_en, ex_jmp_target, if_pred_en, if_pred_target,
    output stall, pc_jmp_enable, pc_jmp_target, pc_pred_enable, pc_prediction,
    output flush_if, flush_id, redirect_busy
`ifdef PIPE_REDIRECT_STATS_EN
    , output stat_stall_cycles, stat_redirects
`endif
  );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// rtl/pipe_redirect_ctrl.sv - stall vector, redirect arbitration/hold and post-redirect squash
// Optional statistics counters are built when PIPE_REDIRECT_STATS_EN is defined.
module pipe_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
`ifdef PIPE_REDIRECT_STATS_EN
  , parameter int CNT_W      = 32
`endif
) (
  input logic                clk,
  input logic                rst,
  pipe_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  localparam logic [3:0] SQ_INIT = 4'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [3:0]        sq_q, sq_d;

  logic [5:0]        stall_vec;
  logic              pc_stall;
  logic              if_stall;
  logic              ex_take;
  logic              ex_issue;
  logic              ex_defer;
  logic              hold_exit;

  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              pred_en;
  logic [ADDR_W-1:0] pred_tgt;
  logic              fl_if;
  logic              fl_id;

  always_comb begin
    if (bus.stallreq_mem)      stall_vec = 6'b011111;
    else if (bus.stallreq_id)  stall_vec = 6'b000111;
    else if (bus.stallreq_if)  stall_vec = 6'b000011;
    else                       stall_vec = 6'b000000;
  end

  assign pc_stall  = stall_vec[0];
  assign if_stall  = stall_vec[1];
  // An EX jump seen in HOLD belongs to the wrong path and is never taken.
  assign ex_take   = (state_q != HOLD) && bus.ex_jmp_en;
  assign ex_issue  = ex_take && !pc_stall;
  assign ex_defer  = ex_take && pc_stall;
  assign hold_exit = (state_q == HOLD) && !pc_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= '0;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sq_q    <= sq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    sq_d    = sq_q;
    if (ex_issue || hold_exit) begin
      state_d = (FLUSH_CYCLES == 0) ? RUN : SQUASH;
      sq_d    = SQ_INIT;
    end else if (ex_defer) begin
      state_d = HOLD;
      pend_d  = bus.ex_jmp_target;
    end else if ((state_q == SQUASH) && !if_stall) begin
      if (sq_q <= 4'd1) begin
        state_d = RUN;
        sq_d    = 4'd0;
      end else begin
        sq_d    = sq_q - 4'd1;
      end
    end
  end

  always_comb begin
    jmp_en   = 1'b0;
    jmp_tgt  = '0;
    pred_en  = 1'b0;
    pred_tgt = '0;
    fl_if    = 1'b0;
    fl_id    = 1'b0;
    case (state_q)
      HOLD: begin
        jmp_en  = 1'b1;
        jmp_tgt = pend_q;
        fl_id   = 1'b1;
      end
      default: begin
        if (ex_take) begin
          fl_if = 1'b1;
          fl_id = 1'b1;
          if (!pc_stall) begin
            jmp_en  = 1'b1;
            jmp_tgt = bus.ex_jmp_target;
          end
        end else if (state_q == RUN) begin
          pred_en  = bus.if_pred_en;
          pred_tgt = bus.if_pred_target;
        end
      end
    endcase
  end

  // Reset forces every output low combinationally, independent of the clock.
  assign bus.stall          = rst ? stall_vec : 6'b000000;
  assign bus.pc_jmp_enable  = rst & jmp_en;
  assign bus.pc_jmp_target  = rst ? jmp_tgt : '0;
  assign bus.pc_pred_enable = rst & pred_en;
  assign bus.pc_prediction  = rst ? pred_tgt : '0;
  assign bus.flush_if       = rst & fl_if;
  assign bus.flush_id       = rst & fl_id;
  assign bus.redirect_busy  = rst & (state_q != RUN);

`ifdef PIPE_REDIRECT_STATS_EN
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;
  logic [CNT_W-1:0] stat_redir_q, stat_redir_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_redir_d = stat_redir_q;
    if (pc_stall && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + CNT_W'(1);
    if ((ex_issue || hold_exit) && (stat_redir_q != '1))
      stat_redir_d = stat_redir_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_q <= '0;
      stat_redir_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_redir_q <= stat_redir_d;
    end
  end

  assign bus.stat_stall_cycles = rst ? stat_stall_q : '0;
  assign bus.stat_redirects    = rst ? stat_redir_q : '0;
`endif
endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// tb/tb_pipe_redirect_ctrl.sv - scoreboard bench for pipe_redirect_ctrl
// Stats checks are compiled in when PIPE_REDIRECT_STATS_EN is defined.
module tb_pipe_redirect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [74:0] out_t;
  typedef struct packed {
    logic        mem;
    logic        id;
    logic        ifs;
    logic        ex;
    logic [31:0] ext;
    logic        pe;
    logic [31:0] pt;
  } stim_t;

  out_t sb[$];

  pipe_redirect_ctrl_if bus ();
  pipe_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PIPE_REDIRECT_STATS_EN
  logic [63:0] stat_sb[$];
  pipe_redirect_ctrl_if #(.CNT_W(4)) bus4 ();
  pipe_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
`endif

  function automatic stim_t S(input logic mem, id, ifs, ex, input logic [31:0] ext,
                              input logic pe, input logic [31:0] pt);
    return {mem, id, ifs, ex, ext, pe, pt};
  endfunction

  function automatic out_t E(input logic [5:0] st, input logic je, input logic [31:0] jt,
                             input logic pe, input logic [31:0] pt,
                             input logic fi, input logic fd, input logic bz);
    return {st, je, jt, pe, pt, fi, fd, bz};
  endfunction

  function automatic out_t obs();
    return {bus.stall, bus.pc_jmp_enable, bus.pc_jmp_target, bus.pc_pred_enable,
            bus.pc_prediction, bus.flush_if, bus.flush_id, bus.redirect_busy};
  endfunction

  task automatic drive(input stim_t s);
    bus.stallreq_mem   = s.mem;
    bus.stallreq_id    = s.id;
    bus.stallreq_if    = s.ifs;
    bus.ex_jmp_en      = s.ex;
    bus.ex_jmp_target  = s.ext;
    bus.if_pred_en     = s.pe;
    bus.if_pred_target = s.pt;
  endtask

  task automatic test_reset();
    out_t got, want;
    drive(S(1, 0, 0, 1, 32'h40, 1, 32'h80));
    #3;
    sb.push_back(E(6'b0, 0, 0, 0, 0, 0, 0, 0));
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_async got=%h want=%h", got, want);
    end
    drive(S(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    sb.push_back(E(6'b0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_release got=%h want=%h", got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_vector();
    stim_t st[5];
    out_t  ex[5];
    out_t  got, want;
    st = '{S(0, 1, 0, 0, 0, 0, 0), S(1, 1, 0, 0, 0, 0, 0), S(0, 0, 1, 0, 0, 1, 32'h44),
           S(0, 0, 0, 0, 0, 0, 0), S(1, 1, 1, 0, 0, 0, 0)};
    ex = '{E(6'b000111, 0, 0, 0, 0, 0, 0, 0), E(6'b011111, 0, 0, 0, 0, 0, 0, 0),
           E(6'b000011, 0, 0, 1, 32'h44, 0, 0, 0), E(6'b000000, 0, 0, 0, 0, 0, 0, 0),
           E(6'b011111, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall_vector[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t st[4];
    out_t  ex[4];
    out_t  got, want;
    st = '{S(0, 0, 0, 1, 32'h1000, 1, 32'h500), S(0, 0, 0, 0, 0, 1, 32'h504),
           S(0, 0, 0, 0, 0, 1, 32'h508), S(0, 0, 0, 0, 0, 1, 32'h50c)};
    ex = '{E(0, 1, 32'h1000, 0, 0, 1, 1, 0), E(0, 0, 0, 0, 0, 0, 0, 1),
           E(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 1, 32'h50c, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL redirect[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_squash_if_stall();
    stim_t st[5];
    out_t  ex[5];
    out_t  got, want;
    st = '{S(0, 0, 0, 1, 32'h600, 0, 0), S(0, 0, 1, 0, 0, 1, 32'h10),
           S(0, 0, 0, 0, 0, 1, 32'h14), S(0, 0, 0, 0, 0, 1, 32'h18),
           S(0, 0, 0, 0, 0, 1, 32'h20)};
    ex = '{E(0, 1, 32'h600, 0, 0, 1, 1, 0), E(6'b000011, 0, 0, 0, 0, 0, 0, 1),
           E(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0, 0, 0, 1),
           E(0, 0, 0, 1, 32'h20, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL squash_if_stall[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    stim_t st[7];
    out_t  ex[7];
    out_t  got, want;
    st = '{S(1, 0, 0, 1, 32'h2040, 0, 0), S(1, 0, 0, 1, 32'hDEAD0000, 1, 32'h99),
           S(1, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 0, 0),
           S(0, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 1, 32'h70)};
    ex = '{E(6'b011111, 0, 0, 0, 0, 1, 1, 0), E(6'b011111, 1, 32'h2040, 0, 0, 0, 1, 1),
           E(6'b011111, 1, 32'h2040, 0, 0, 0, 1, 1), E(0, 1, 32'h2040, 0, 0, 0, 1, 1),
           E(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0, 0, 0, 1),
           E(0, 0, 0, 1, 32'h70, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL hold[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[6];
    out_t  ex[6];
    out_t  got, want;
    st = '{S(0, 0, 0, 1, 32'h100, 1, 32'h200), S(0, 0, 0, 0, 0, 1, 32'h204),
           S(0, 0, 0, 1, 32'h300, 1, 32'h204), S(0, 0, 0, 0, 0, 0, 0),
           S(0, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 1, 32'h208)};
    ex = '{E(0, 1, 32'h100, 0, 0, 1, 1, 0), E(0, 0, 0, 0, 0, 0, 0, 1),
           E(0, 1, 32'h300, 0, 0, 1, 1, 1), E(0, 0, 0, 0, 0, 0, 0, 1),
           E(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 1, 32'h208, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset_hold();
    stim_t st[5];
    out_t  ex[5];
    out_t  got, want;
    st = '{S(1, 0, 0, 1, 32'h3000, 0, 0), S(1, 0, 0, 0, 0, 0, 0), S(1, 0, 0, 0, 0, 0, 0),
           S(0, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 1, 32'h90)};
    ex = '{E(6'b011111, 0, 0, 0, 0, 1, 1, 0), E(6'b011111, 1, 32'h3000, 0, 0, 0, 1, 1),
           E(0, 0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, 0),
           E(0, 0, 0, 1, 32'h90, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      if (i == 3) rst = 1'b1;
      @(negedge clk);
      if (i == 2) begin
        #2 rst = 1'b0;
        #1;
      end
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL async_reset_hold[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef PIPE_REDIRECT_STATS_EN
  task automatic test_stats();
    logic [63:0] want;
    logic [63:0] got;
    rst = 1'b0; #2; rst = 1'b1;
    drive(S(0, 0, 0, 0, 0, 0, 0));
    bus4.stallreq_mem = 1'b1;
    stat_sb.push_back({32'd5, 32'd2});
    stat_sb.push_back({32'd15, 32'd0});
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(S(1, 0, 0, 0, 0, 0, 0)); @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 3) drive(S(0, 0, 0, 1, 32'h1000 + i, 0, 0));
      else drive(S(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    got = {32'(bus.stat_stall_cycles), 32'(bus.stat_redirects)};
    want = stat_sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL stats_count got=%h want=%h", got, want);
    end
    got = {32'(bus4.stat_stall_cycles), 32'(bus4.stat_redirects)};
    want = stat_sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL stats_saturate got=%h want=%h", got, want);
    end
    bus4.stallreq_mem = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIPE_REDIRECT_STATS_EN
    bus4.stallreq_if = 0; bus4.stallreq_id = 0; bus4.stallreq_mem = 0;
    bus4.ex_jmp_en = 0; bus4.ex_jmp_target = '0;
    bus4.if_pred_en = 0; bus4.if_pred_target = '0;
`endif
    test_reset();
    test_stall_vector();
    test_redirect();
    test_squash_if_stall();
    test_hold();
    test_back_to_back();
    test_async_reset_hold();
`ifdef PIPE_REDIRECT_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_redirect_ctrl.md
Name: pipe_redirect_ctrl

Overview:
- Pipeline control unit sitting between the hazard sources (IF, ID, MEM stall requests), the EX branch resolver and the IF branch predictor, and the PC register.
- Builds the per-stage stall vector.
- Arbitrates redirect sources (EX jump beats IF prediction), holds an EX redirect while the PC is stalled, and squashes wrong-path fetches for a fixed number of cycles after every redirect.

Parameters:
- ADDR_W, 32, width of PC/target addresses
- FLUSH_CYCLES, 2, post-redirect cycles in which predictions are suppressed (0..15)
- CNT_W, 32, width of statistics counters (optional feature only)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-low (asserted at 0)
- stallreq_if  input  1  fetch waiting on memory
- stallreq_id  input  1  load-use hazard
- stallreq_mem  input  1  memory stage busy
- ex_jmp_en  input  1  EX resolved a taken/mispredicted jump
- ex_jmp_target  input  ADDR_W  EX jump target
- if_pred_en  input  1  predictor says taken
- if_pred_target  input  ADDR_W  predicted target
- stall  output  6  stage stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- pc_jmp_enable  output  1  redirect to PC register
- pc_jmp_target  output  ADDR_W  redirect target
- pc_pred_enable  output  1  prediction forwarded to PC register
- pc_prediction  output  ADDR_W  forwarded prediction target
- flush_if  output  1  kill IF/ID latch contents
- flush_id  output  1  kill ID/EX latch contents
- redirect_busy  output  1  state != RUN

Behaviour:
- Stall vector is combinational, priority mem > id > if:
  - stallreq_mem gives 6'b011111
  - else stallreq_id gives 6'b000111
  - else stallreq_if gives 6'b000011
  - else 6'b000000
- While rst=0, every output is 0. Internal state resets to RUN, pend_target=0, sq_cnt=0.
- FSM states: RUN, HOLD, SQUASH.
- RUN:
  - ex_jmp_en=1 and stall[0]=0: pc_jmp_enable=1 and pc_jmp_target=ex_jmp_target in the same cycle (zero latency); flush_if=flush_id=1.
    - Next state is SQUASH with sq_cnt=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
  - ex_jmp_en=1 and stall[0]=1: latch pend_target=ex_jmp_target, assert flush_if=flush_id=1, next state HOLD.
  - Otherwise pc_pred_enable=if_pred_en, pc_prediction=if_pred_target, and pc_jmp_enable=0.
- HOLD:
  - pc_jmp_enable=1, pc_jmp_target=pend_target, pc_pred_enable=0, flush_id=1 every cycle.
  - ex_jmp_en is ignored: it comes from a wrong-path instruction.
  - On the first cycle with stall[0]=0, the redirect is consumed; next state is SQUASH with sq_cnt=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
- SQUASH:
  - pc_pred_enable=0, pc_jmp_enable=0.
  - sq_cnt decrements only on cycles with stall[1]=0; when sq_cnt reaches 1 and decrements, next state is RUN.
  - ex_jmp_en=1 in SQUASH is a genuine older-path jump. It is handled exactly as in RUN, restarting sq_cnt.
- Simultaneous ex_jmp_en and if_pred_en: EX wins and the prediction is dropped (pc_pred_enable=0).
- Stall requests never block the FSM except as stated above. flush_* outputs are combinational from state and inputs.
- Asynchronous reset mid-HOLD/SQUASH returns to RUN immediately and drops the pending target.

Optional Feature:
- Macro PIPE_REDIRECT_STATS_EN.
- When defined, adds output ports stat_stall_cycles (CNT_W) and stat_redirects (CNT_W):
  - stat_stall_cycles counts cycles with stall[0]=1.
  - stat_redirects counts consumed redirects (RUN/SQUASH zero-latency issue, or HOLD exit).
  - Both are saturating at all-ones and reset to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Only stallreq_id=1 → stall=6'b000111; then add stallreq_mem=1 → 6'b011111; release all → 6'b000000.
- RUN, ex_jmp_en=1, target 0x0000_1000, no stall → same cycle pc_jmp_enable=1, target 0x1000, flush_if=flush_id=1; next 2 unstalled cycles have if_pred_en=1 but pc_pred_enable=0; third cycle pc_pred_enable=1.
- stallreq_mem=1 for 3 cycles, ex_jmp_en pulse with target 0x0000_2040 in cycle 1 → redirect_busy=1, pc_jmp_enable=1/target 0x2040 held through the stall; a second ex_jmp_en with target 0xDEAD_0000 in HOLD is ignored; exit to SQUASH on stall release.
- ex_jmp_en=1 and if_pred_en=1 with targets 0x100/0x200 in the same cycle → pc_jmp_target=0x100, pc_pred_enable=0.
- Drive rst=0 asynchronously mid-HOLD → all outputs 0 without a clock edge; after release state is RUN and pc_jmp_enable=0.
- With PIPE_REDIRECT_STATS_EN: 5 stalled cycles plus 2 redirects → stat_stall_cycles=5, stat_redirects=2; with CNT_W=4, 20 stalled cycles → saturates at 15.
